proc_ctrl: RTL and testbench
============================

Name: proc_ctrl

Overview:
Multicycle fetch/decode/execute sequencer for the 9-bit simple processor. It is the initiator on the register-file port: it drives the write enable, write address and write data, and both read addresses. It consumes the two combinational read-data buses. It fetches 9-bit instructions over a valid-qualified memory port, executes them with an internal ALU and writes results back.

Parameters:
PC_W, 8, program counter / instruction address width
DATA_W, 9, register and instruction width (fixed by ISA; not to be overridden)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
start  in  1  begin execution from pc=0; sampled only in IDLE
imem_req  out  1  fetch request, high throughout FETCH
imem_addr  out  PC_W  fetch address, equals pc
imem_valid  in  1  imem_data valid; may assert in the same cycle as imem_req
imem_data  in  9  instruction word
rf_wr_en  out  1  register-file write strobe
rf_wr_addr  out  2  destination register
rf_wr_data  out  9  write-back data
rf_rd0_addr  out  2  source A address
rf_rd1_addr  out  2  source B address
rf_rd0_data  in  9  source A data (combinational from rd0 address)
rf_rd1_data  in  9  source B data
busy  out  1  high in FETCH/DECODE/EXEC/WB
halted  out  1  high in HALTED

Behaviour:
- Instruction fields: ir[8:6] = op, ir[5:4] = rd, ir[3:2] = rs1, ir[1:0] = rs2; imm4 = ir[3:0].
- Opcodes: 000 NOP; 001 ADD; 010 SUB; 011 AND; 100 OR; 101 LDI (rd = zero-extended imm4); 110 MOV (rd = rs1); 111 HALT.
- Arithmetic is modulo 2^9. There is no carry and no flags. SUB is rs1 - rs2 in two's complement.
- States are IDLE, FETCH, DECODE, EXEC, WB, HALTED.
  - IDLE: on start go to FETCH with pc = 0.
  - FETCH: imem_req = 1. On a clk edge with imem_valid = 1, load ir <= imem_data and go to DECODE. Otherwise hold.
  - DECODE: rf_rd0_addr = ir[3:2] and rf_rd1_addr = ir[1:0] (driven combinationally from ir in every state). Capture opa <= rf_rd0_data and opb <= rf_rd1_data. Go to EXEC.
  - EXEC: result <= alu(op, opa, opb, imm4).
    - NOP: pc <= pc + 1, go to FETCH.
    - HALT: go to HALTED; pc is not advanced.
    - All other opcodes: go to WB.
  - WB: rf_wr_en = 1, rf_wr_addr = ir[5:4], rf_wr_data = result. Also pc <= pc + 1. Go to FETCH.
  - HALTED: terminal; only rst leaves it. start is ignored.
- rf_wr_en is a pure decode of state == WB. It is high for exactly one cycle per writing instruction, never in any other state, and glitch-free.
- Latency: with imem_valid arriving in the same cycle as the request, a writing instruction takes 4 cycles, NOP takes 3 and HALT takes 3.
- pc wraps from 2^PC_W - 1 to 0 with no error.
- start asserted outside IDLE is ignored. imem_valid outside FETCH is ignored.
- Same-register hazards need no forwarding: WB completes before the next DECODE.
- Reset (async, any state, including mid-WB) forces:
  - state = IDLE, pc = 0, ir = 0, opa = opb = result = 0;
  - all outputs = 0: rf_wr_en, imem_req, busy, halted, all addresses and rf_wr_data.
  - A write in progress is aborted and rf_wr_en falls immediately.

Optional Feature:
PROC_CTRL_PERF_CNT_EN
- Defined: adds output retired_cnt (16 bits). It is reset to 0 and increments by 1 on leaving EXEC for every instruction except HALT. It saturates at 16'hFFFF.
- Undefined: the port and the counter are absent. All other behaviour is identical.

Decomposition:
- Package proc_pkg holds:
  - opcode localparams (OP_NOP … OP_HALT);
  - the state encoding (3-bit, ST_IDLE … ST_HALTED);
  - field-slice constants;
  - DATA_W = 9 and REG_ADDR_W = 2.
- Sub-module proc_alu: purely combinational. Inputs are op, a, b and imm4; output is a 9-bit result. It is instantiated once and is unit-testable alone.
- The FSM, pc, ir and operand registers stay in proc_ctrl.

Test Plan:
- Reset then start, program "LDI r1,5; LDI r2,3; ADD r3,r1,r2; HALT":
  - writes (1,5), (2,3), (3,8), each as a single-cycle rf_wr_en pulse;
  - halted = 1 at pc = 3.
- SUB wrap, r1 = 0 and r2 = 1, "SUB r0,r1,r2": rf_wr_data = 9'h1FF written to r0.
- Fetch stall, imem_valid delayed 3 cycles on each fetch: imem_req is held high with imem_addr stable, there are no spurious writes, and results match the zero-stall run.
- Back-to-back dependency "LDI r0,7; MOV r1,r0; ADD r1,r1,r0": writes (0,7), (1,7), (1,14).
- Reset asserted during WB of LDI r2,9: rf_wr_en drops asynchronously, all outputs are 0, and after start execution restarts at pc = 0.
- NOP sequence at pc = 255, "NOP" then the word fetched at 0: there is no write, pc wraps to 0, and the NOP takes 3 cycles. With PROC_CTRL_PERF_CNT_EN defined, retired_cnt increments by 1.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared ISA constants, field slices and FSM encoding for the 9-bit processor.
package proc_pkg;

  localparam int DATA_W     = 9;
  localparam int REG_ADDR_W = 2;
  localparam int OP_W       = 3;
  localparam int IMM_W      = 4;

  localparam logic [OP_W-1:0] OP_NOP  = 3'b000;
  localparam logic [OP_W-1:0] OP_ADD  = 3'b001;
  localparam logic [OP_W-1:0] OP_SUB  = 3'b010;
  localparam logic [OP_W-1:0] OP_AND  = 3'b011;
  localparam logic [OP_W-1:0] OP_OR   = 3'b100;
  localparam logic [OP_W-1:0] OP_LDI  = 3'b101;
  localparam logic [OP_W-1:0] OP_MOV  = 3'b110;
  localparam logic [OP_W-1:0] OP_HALT = 3'b111;

  localparam int OP_MSB  = 8;
  localparam int OP_LSB  = 6;
  localparam int RD_MSB  = 5;
  localparam int RD_LSB  = 4;
  localparam int RS1_MSB = 3;
  localparam int RS1_LSB = 2;
  localparam int RS2_MSB = 1;
  localparam int RS2_LSB = 0;
  localparam int IMM_MSB = 3;
  localparam int IMM_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_HALTED = 3'd5
  } state_e;

endpackage

// File: rtl/proc_alu.sv
// Combinational ALU: modulo-2^9 arithmetic, no carry and no flags.
module proc_alu
  import proc_pkg::*;
(
  input  logic [OP_W-1:0]   op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [IMM_W-1:0]  imm4_i,
  output logic [DATA_W-1:0] result_o
);

  always_comb begin
    result_o = '0;
    case (op_i)
      OP_ADD:  result_o = a_i + b_i;
      OP_SUB:  result_o = a_i - b_i;
      OP_AND:  result_o = a_i & b_i;
      OP_OR:   result_o = a_i | b_i;
      OP_LDI:  result_o = {{(DATA_W-IMM_W){1'b0}}, imm4_i};
      OP_MOV:  result_o = a_i;
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/proc_ctrl.sv
// Multicycle fetch/decode/execute/writeback sequencer for the 9-bit processor.
// Optional retired-instruction counter enabled by PROC_CTRL_PERF_CNT_EN.
module proc_ctrl
  import proc_pkg::*;
#(
  parameter int PC_W = 8
)
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  imem_req,
  output logic [PC_W-1:0]       imem_addr,
  input  logic                  imem_valid,
  input  logic [DATA_W-1:0]     imem_data,
  output logic                  rf_wr_en,
  output logic [REG_ADDR_W-1:0] rf_wr_addr,
  output logic [DATA_W-1:0]     rf_wr_data,
  output logic [REG_ADDR_W-1:0] rf_rd0_addr,
  output logic [REG_ADDR_W-1:0] rf_rd1_addr,
  input  logic [DATA_W-1:0]     rf_rd0_data,
  input  logic [DATA_W-1:0]     rf_rd1_data,
  output logic                  busy,
  output logic                  halted,
`ifdef PROC_CTRL_PERF_CNT_EN
  output logic [15:0]           retired_cnt,
`endif
  output logic [2:0]            dbg_state
);

  state_e              state_q;
  logic [PC_W-1:0]     pc_q;
  logic [DATA_W-1:0]   ir_q;
  logic [DATA_W-1:0]   opa_q;
  logic [DATA_W-1:0]   opb_q;
  logic [DATA_W-1:0]   result_q;
  logic [DATA_W-1:0]   alu_result;
  logic [OP_W-1:0]     op;
  logic [PC_W-1:0]     pc_d;

  assign op   = ir_q[OP_MSB:OP_LSB];
  assign pc_d = pc_q + PC_W'(1);

  proc_alu u_alu (
    .op_i     (op),
    .a_i      (opa_q),
    .b_i      (opb_q),
    .imm4_i   (ir_q[IMM_MSB:IMM_LSB]),
    .result_o (alu_result)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      ir_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (start) begin
          pc_q    <= '0;
          state_q <= ST_FETCH;
        end
        ST_FETCH: if (imem_valid) begin
          ir_q    <= imem_data;
          state_q <= ST_DECODE;
        end
        ST_DECODE: begin
          opa_q   <= rf_rd0_data;
          opb_q   <= rf_rd1_data;
          state_q <= ST_EXEC;
        end
        ST_EXEC: begin
          result_q <= alu_result;
          case (op)
            OP_NOP: begin
              pc_q    <= pc_d;
              state_q <= ST_FETCH;
            end
            OP_HALT: state_q <= ST_HALTED;
            default: state_q <= ST_WB;
          endcase
        end
        ST_WB: begin
          pc_q    <= pc_d;
          state_q <= ST_FETCH;
        end
        ST_HALTED: state_q <= ST_HALTED;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  // Outputs decode registered state only, so reset clears them without waiting for a clock.
  assign imem_req    = (state_q == ST_FETCH);
  assign imem_addr   = pc_q;
  assign rf_wr_en    = (state_q == ST_WB);
  assign rf_wr_addr  = ir_q[RD_MSB:RD_LSB];
  assign rf_wr_data  = result_q;
  assign rf_rd0_addr = ir_q[RS1_MSB:RS1_LSB];
  assign rf_rd1_addr = ir_q[RS2_MSB:RS2_LSB];
  assign busy        = (state_q == ST_FETCH) || (state_q == ST_DECODE) ||
                       (state_q == ST_EXEC)  || (state_q == ST_WB);
  assign halted      = (state_q == ST_HALTED);
  assign dbg_state   = state_q;

`ifdef PROC_CTRL_PERF_CNT_EN
  logic [15:0] retired_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_q <= '0;
    end else if ((state_q == ST_EXEC) && (op != OP_HALT) && (retired_q != 16'hFFFF)) begin
      retired_q <= retired_q + 16'd1;
    end
  end

  assign retired_cnt = retired_q;
`endif

endmodule

// File: tb/tb_proc_ctrl.sv
// Directed bench for proc_ctrl: memory/regfile models, write scoreboard and final report.
module tb_proc_ctrl;
  import proc_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_valid;
  logic [8:0]  imem_data;
  logic        rf_wr_en;
  logic [1:0]  rf_wr_addr;
  logic [8:0]  rf_wr_data;
  logic [1:0]  rf_rd0_addr;
  logic [1:0]  rf_rd1_addr;
  logic [8:0]  rf_rd0_data;
  logic [8:0]  rf_rd1_data;
  logic        busy;
  logic        halted;
  logic [2:0]  dbg_state;
`ifdef PROC_CTRL_PERF_CNT_EN
  logic [15:0] retired_cnt;
`endif

  proc_ctrl #(.PC_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_valid  (imem_valid),
    .imem_data   (imem_data),
    .rf_wr_en    (rf_wr_en),
    .rf_wr_addr  (rf_wr_addr),
    .rf_wr_data  (rf_wr_data),
    .rf_rd0_addr (rf_rd0_addr),
    .rf_rd1_addr (rf_rd1_addr),
    .rf_rd0_data (rf_rd0_data),
    .rf_rd1_data (rf_rd1_data),
    .busy        (busy),
    .halted      (halted),
`ifdef PROC_CTRL_PERF_CNT_EN
    .retired_cnt (retired_cnt),
`endif
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- environment models ----------------
  logic [8:0] mem [256];
  logic [8:0] rf  [4];
  int         stall_cyc = 0;
  int         wait_cnt  = 0;
  logic [7:0] fetch_addr;

  assign rf_rd0_data = rf[rf_rd0_addr];
  assign rf_rd1_data = rf[rf_rd1_addr];

  always @(posedge clk) begin
    if (rf_wr_en) rf[rf_wr_addr] <= rf_wr_data;
  end

  // Memory answers imem_req after stall_cyc cycles; address must not move while waiting.
  always @(negedge clk) begin
    if (imem_req) begin
      if (wait_cnt == 0) fetch_addr = imem_addr;
      else check("fetch_addr_stable", 32'(imem_addr), 32'(fetch_addr));
      imem_valid = (wait_cnt >= stall_cyc);
      imem_data  = mem[imem_addr];
      wait_cnt++;
    end else begin
      imem_valid = 1'b0;
      imem_data  = '0;
      wait_cnt   = 0;
    end
  end

  // ---------------- write scoreboard ----------------
  logic [10:0] exp_q[$];
  int          extra_wr = 0;

  always @(negedge clk) begin
    if (rf_wr_en) begin
      if (exp_q.size() > 0) check("rf_write", 32'({rf_wr_addr, rf_wr_data}), 32'(exp_q.pop_front()));
      else extra_wr++;
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [8:0] ins(input logic [2:0] op, input logic [1:0] rd,
                                     input logic [1:0] a, input logic [1:0] b);
    return {op, rd, a, b};
  endfunction

  function automatic logic [8:0] ldi(input logic [1:0] rd, input logic [3:0] imm);
    return {OP_LDI, rd, imm};
  endfunction

  task automatic fill_mem(input logic [8:0] w);
    for (int i = 0; i < 256; i++) mem[i] = w;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"},  32'({rf_wr_en, imem_req, busy, halted}), 32'h0);
    check({tag, "_addr"}, 32'(imem_addr), 32'h0);
    check({tag, "_rfa"},  32'({rf_wr_addr, rf_rd0_addr, rf_rd1_addr}), 32'h0);
    check({tag, "_wdat"}, 32'(rf_wr_data), 32'h0);
  endtask

  task automatic run_to_halt(input int max, output int cycles);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("first_fetch_addr", 32'({imem_req, busy, imem_addr}), 32'({1'b1, 1'b1, 8'h00}));
    cycles = 0;
    while (!halted && cycles < max) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    check("halt_reached", 32'(halted), 32'h1);
  endtask

  task automatic end_test(input string name);
    check({name, "_pending_writes"}, 32'(exp_q.size()), 32'h0);
    check({name, "_extra_writes"}, 32'(extra_wr), 32'h0);
    extra_wr = 0;
    exp_q.delete();
  endtask

  task automatic load_prog1();
    fill_mem({OP_HALT, 6'd0});
    mem[0] = ldi(2'd1, 4'd5);
    mem[1] = ldi(2'd2, 4'd3);
    mem[2] = ins(OP_ADD, 2'd3, 2'd1, 2'd2);
    mem[3] = {OP_HALT, 6'd0};
  endtask

  // ---------------- test sequence ----------------
  int          cyc;
  logic [8:0]  old_r2;
  logic [15:0] cnt_snap;
  bit          found;

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    imem_valid = 1'b0;
    imem_data  = '0;
    cnt_snap   = '0;
    fill_mem({OP_HALT, 6'd0});
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("por");
    check("por_state", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("idle_without_start", 32'({busy, imem_req}), 32'h0);

    // LDI r1,5; LDI r2,3; ADD r3,r1,r2; HALT -> 3*4 + 3 cycles
    load_prog1();
    exp_q.push_back({2'd1, 9'd5});
    exp_q.push_back({2'd2, 9'd3});
    exp_q.push_back({2'd3, 9'd8});
    run_to_halt(100, cyc);
    check("prog1_cycles", 32'(cyc), 32'd15);
    check("prog1_halt_pc", 32'(imem_addr), 32'd3);
    check("prog1_r3", 32'(rf[3]), 32'd8);
    check("prog1_idle_flags", 32'({busy, imem_req}), 32'h0);
`ifdef PROC_CTRL_PERF_CNT_EN
    check("prog1_retired", 32'(retired_cnt), 32'd3);
`endif
    @(negedge clk);
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1 start = 1'b0;
    check("halted_ignores_start", 32'({halted, imem_req, busy}), 32'({1'b1, 1'b0, 1'b0}));
    end_test("prog1");

    // SUB r0, r1(=0), r2(=1) wraps to 0x1FF
    apply_reset();
    fill_mem({OP_HALT, 6'd0});
    mem[0] = ldi(2'd1, 4'd0);
    mem[1] = ldi(2'd2, 4'd1);
    mem[2] = ins(OP_SUB, 2'd0, 2'd1, 2'd2);
    exp_q.push_back({2'd1, 9'd0});
    exp_q.push_back({2'd2, 9'd1});
    exp_q.push_back({2'd0, 9'h1FF});
    run_to_halt(100, cyc);
    check("sub_r0", 32'(rf[0]), 32'h1FF);
    end_test("sub_wrap");

    // Program 1 again with every fetch stalled 3 cycles
    apply_reset();
    stall_cyc = 3;
    load_prog1();
    exp_q.push_back({2'd1, 9'd5});
    exp_q.push_back({2'd2, 9'd3});
    exp_q.push_back({2'd3, 9'd8});
    run_to_halt(200, cyc);
    check("stall_cycles", 32'(cyc), 32'd27);
    check("stall_halt_pc", 32'(imem_addr), 32'd3);
    end_test("stall");
    stall_cyc = 0;

    // LDI r0,7; MOV r1,r0; ADD r1,r1,r0
    apply_reset();
    fill_mem({OP_HALT, 6'd0});
    mem[0] = ldi(2'd0, 4'd7);
    mem[1] = ins(OP_MOV, 2'd1, 2'd0, 2'd0);
    mem[2] = ins(OP_ADD, 2'd1, 2'd1, 2'd0);
    exp_q.push_back({2'd0, 9'd7});
    exp_q.push_back({2'd1, 9'd7});
    exp_q.push_back({2'd1, 9'd14});
    run_to_halt(100, cyc);
    check("dep_cycles", 32'(cyc), 32'd15);
    end_test("dep");

    // Reset lands during WB of LDI r2,9; the write must be aborted
    apply_reset();
    fill_mem({OP_HALT, 6'd0});
    mem[0] = ldi(2'd2, 4'd9);
    old_r2 = rf[2];
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk);
      #1 found = rf_wr_en;
    end
    check("wb_reached", 32'(rf_wr_en), 32'h1);
    rst = 1'b1;
    #1;
    check_all_zero("rst_in_wb");
    check("rst_in_wb_state", 32'(dbg_state), 32'(ST_IDLE));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("aborted_write_r2", 32'(rf[2]), 32'(old_r2));
    end_test("rst_abort");
    exp_q.push_back({2'd2, 9'd9});
    run_to_halt(100, cyc);
    check("restart_cycles", 32'(cyc), 32'd7);
    check("restart_halt_pc", 32'(imem_addr), 32'd1);
    end_test("restart");

    // All-NOP memory: walk pc to 255, then the NOP there wraps pc to 0 (HALT placed at 0)
    apply_reset();
    fill_mem(9'h000);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(posedge clk);
      #1 found = imem_req && (imem_addr == 8'd255);
    end
    check("reached_pc255", 32'({imem_req, imem_addr}), 32'({1'b1, 8'd255}));
`ifdef PROC_CTRL_PERF_CNT_EN
    cnt_snap = retired_cnt;
`endif
    mem[0] = {OP_HALT, 6'd0};
    cyc = 0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      found = imem_req && (imem_addr == 8'd0);
    end
    check("nop_wrap_cycles", 32'(cyc), 32'd3);
    check("nop_wrap_pc", 32'({imem_req, imem_addr}), 32'({1'b1, 8'd0}));
    for (int i = 0; i < 10 && !halted; i++) begin
      @(posedge clk);
      #1;
    end
    check("nop_halted", 32'({halted, imem_addr}), 32'({1'b1, 8'd0}));
`ifdef PROC_CTRL_PERF_CNT_EN
    check("nop_retired_inc", 32'(retired_cnt), 32'(cnt_snap + 16'd1));
`endif
    end_test("nop_wrap");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
